// File: rtl/mux_8_1_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 mux between 8 requesters.
// Ports: i_clk, i_rst (async high), i_req[7:0], i_code[7:0],
//   o_gnt[7:0] one-hot, o_sel_code[2:0], o_en, o_f = selected data.
// Optional macro MUX_ARB_LOCK_EN adds i_lock, which extends a
//   grant past its hold limit while the grantee keeps requesting.
module mux_8_1_rr_arbiter #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
`ifdef MUX_ARB_LOCK_EN
  input  logic       i_lock,
`endif
  input  logic [7:0] i_req,
  input  logic [7:0] i_code,
  output logic [7:0] o_gnt,
  output logic [2:0] o_sel_code,
  output logic       o_en,
  output logic       o_f
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state_q;
  logic [7:0]      gnt_q;
  logic [2:0]      sel_q;
  logic [2:0]      last_q;
  logic            en_q;
  logic [HW-1:0]   hold_q;

  logic            lock_w;
  logic            any_req;
  logic [2:0]      win;
  logic [2:0]      idx;
  logic            cur_req;
  logic            at_max;
  logic            rel;

`ifdef MUX_ARB_LOCK_EN
  assign lock_w = i_lock;
`else
  assign lock_w = 1'b0;
`endif

  assign any_req = |i_req;

  // Scan offsets from far to near so the nearest requester after
  // last_q wins; offset 8 wraps back to last_q itself.
  always_comb begin
    win = last_q;
    idx = last_q;
    for (int i = 8; i >= 1; i--) begin
      idx = last_q + 3'(i);
      if (i_req[idx]) win = idx;
    end
  end

  assign cur_req = i_req[sel_q];
  assign at_max  = (hold_q == HW'(HOLD_CYCLES));
  // A dropped request always releases; expiry is masked by lock.
  assign rel     = !cur_req || (at_max && !(lock_w && cur_req));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= 3'd7;
      en_q    <= 1'b0;
      hold_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q <= GRANT;
            sel_q   <= win;
            last_q  <= win;
            gnt_q   <= 8'(1) << win;
            en_q    <= 1'b1;
            hold_q  <= HW'(1);
          end
        end
        GRANT: begin
          if (rel) begin
            if (any_req) begin
              sel_q  <= win;
              last_q <= win;
              gnt_q  <= 8'(1) << win;
              hold_q <= HW'(1);
            end else begin
              state_q <= IDLE;
              gnt_q   <= '0;
              en_q    <= 1'b0;
              hold_q  <= '0;
            end
          end else if (!at_max) begin
            hold_q <= hold_q + HW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_gnt      = gnt_q;
  assign o_sel_code = sel_q;
  assign o_en       = en_q;
  assign o_f        = en_q & i_code[sel_q];

endmodule

// File: tb/tb_mux_8_1_rr_arbiter.sv
// Bench for mux_8_1_rr_arbiter: directed vectors, queued expectations,
// monitor compares each post-edge output set.
module tb_mux_8_1_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic [7:0] code = '0;
  logic       lock = 1'b0;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       en;
  logic       f;

  int ntests = 0;
  int nfail  = 0;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       en;
    logic       f;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  mux_8_1_rr_arbiter #(.HOLD_CYCLES(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
`ifdef MUX_ARB_LOCK_EN
    .i_lock     (lock),
`endif
    .i_req      (req),
    .i_code     (code),
    .o_gnt      (gnt),
    .o_sel_code (sel),
    .o_en       (en),
    .o_f        (f)
  );

  task automatic chk(input string nm, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: 3 time units after each rising edge.
  always @(posedge clk) begin
    #3;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("gnt", int'(gnt), int'(e.gnt));
      chk("sel", int'(sel), int'(e.sel));
      chk("en", int'(en), int'(e.en));
      chk("f", int'(f), int'(e.f));
      chk("onehot0", int'($onehot0(gnt)), 1);
      chk("gnt_sel_en", int'(gnt[sel]), int'(en));
    end
  end

  // One cycle: drive at negedge, push outputs expected after the edge.
  task automatic cyc(input logic [7:0] r, input logic [7:0] c,
                     input int g, input logic [2:0] es);
    exp_t e;
    @(negedge clk);
    req  = r;
    code = c;
    @(posedge clk);
    e.gnt = (g < 0) ? 8'h00 : (8'h01 << g);
    e.sel = es;
    e.en  = (g >= 0);
    e.f   = (g >= 0) && c[es];
    q.push_back(e);
  endtask

  task automatic chk_idle_rst(input string nm);
    chk({nm, "_gnt"}, int'(gnt), 0);
    chk({nm, "_sel"}, int'(sel), 0);
    chk({nm, "_en"}, int'(en), 0);
    chk({nm, "_f"}, int'(f), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    #1;
    chk_idle_rst("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Power-on reset
    #2;
    chk_idle_rst("por");
    @(negedge clk);
    rst = 1'b0;

    // Async reset mid-grant while o_gnt = 8'h10
    cyc(8'h10, 8'h10, 4, 3'd4);
    cyc(8'h10, 8'h10, 4, 3'd4);
    @(negedge clk);
    #2;
    chk("pre_rst_gnt", int'(gnt), 8'h10);
    rst = 1'b1;
    #1;
    chk_idle_rst("mid");
    @(negedge clk);
    req = '0;
    rst = 1'b0;

    // Single requester: continuous grant via re-grant
    for (int k = 0; k < 10; k++) cyc(8'h08, 8'h08, 3, 3'd3);
    cyc(8'h00, 8'h08, -1, 3'd3);

    // Full contention from reset
    do_reset();
    for (int g = 0; g < 8; g++)
      for (int k = 0; k < 4; k++) cyc(8'hFF, 8'hAA, g, 3'(g));
    cyc(8'hFF, 8'hAA, 0, 3'd0);

    // Early drop
    do_reset();
    cyc(8'h81, 8'h80, 0, 3'd0);
    cyc(8'h81, 8'h80, 0, 3'd0);
    cyc(8'h80, 8'h80, 7, 3'd7);
    cyc(8'h00, 8'h80, -1, 3'd7);

    // Wrap-around: 6 expires, search 7,0 -> 0, then back to 6
    cyc(8'h40, 8'h41, 6, 3'd6);
    for (int k = 0; k < 3; k++) cyc(8'h41, 8'h41, 6, 3'd6);
    for (int k = 0; k < 4; k++) cyc(8'h41, 8'h41, 0, 3'd0);
    cyc(8'h41, 8'h41, 6, 3'd6);

    // Drop of grantee with a new request rising in the same cycle
    cyc(8'h04, 8'h04, 2, 3'd2);
    cyc(8'h00, 8'h04, -1, 3'd2);

`ifdef MUX_ARB_LOCK_EN
    do_reset();
    lock = 1'b1;
    for (int k = 0; k < 12; k++) cyc(8'h03, 8'h01, 0, 3'd0);
    @(negedge clk);
    lock = 1'b0;
    cyc(8'h03, 8'h01, 1, 3'd1);
    cyc(8'h00, 8'h01, -1, 3'd1);
`endif

    repeat (3) @(posedge clk);
    #4;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mux_8_1_rr_arbiter.md
Name: mux_8_1_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8:1 mux datapath between 8 requesters.
- Each requester raises a request bit. The arbiter picks a winner, drives the 3-bit select code and enable, and returns the selected data bit.
- Sits directly in front of the 8:1 mux; generates i_sel_code/i_en for it and mirrors its o_f output.

Parameters:
- HOLD_CYCLES, 4: maximum consecutive cycles one requester keeps the grant. Legal range 1..255.

Ports:
- i_clk  in  1  rising-edge clock
- i_rst  in  1  asynchronous, active-high reset
- i_req  in  8  request bit per requester; index = mux input number
- i_code  in  8  data inputs to the shared mux, one bit per requester
- o_gnt  out  8  one-hot grant; all zero when idle
- o_sel_code  out  3  binary index of the current grantee (mux select)
- o_en  out  1  mux enable; 1 while in GRANT
- o_f  out  1  i_code[o_sel_code] when o_en=1, else 0 (combinational from registered select)

Behaviour:
- Reset (async, i_rst=1): state=IDLE, o_gnt=0, o_sel_code=0, o_en=0, o_f=0. Internal registers: last-grant pointer=7 (index 0 has first priority), hold_cnt=0. Effective immediately, including mid-grant.
- Search order: starts at (last+1) mod 8, ascending, wraps past 7 to 0, ends at last itself. First requesting index wins.
- States: IDLE and GRANT. o_gnt, o_sel_code and o_en are registered.
- IDLE:
  - i_req=0: stay IDLE.
  - i_req!=0: at the next edge, go to GRANT. Load winner into o_sel_code and last. Set o_gnt one-hot. Set o_en=1, hold_cnt=1.
  - Latency: request sampled at edge N, grant visible after edge N.
- GRANT, release condition: i_req[o_sel_code]=0, or hold_cnt==HOLD_CYCLES.
- GRANT, no release: hold_cnt increments; outputs stay stable.
- GRANT, on release:
  - If any bit of i_req is set, including the current grantee's, re-arbitrate from (last+1) mod 8 in the same edge. Back-to-back grant, no idle cycle; hold_cnt=1.
  - If only the current grantee still requests after hold expiry, it is re-granted. o_gnt is unchanged; hold_cnt restarts at 1.
  - If i_req=0, go to IDLE with o_gnt=0 and o_en=0. o_sel_code and last keep their values.
- Request dropping and another rising in the same cycle: the drop releases; the new request competes in the same arbitration.
- hold_cnt width: $clog2(HOLD_CYCLES+1). It never exceeds HOLD_CYCLES.
- Invariants: o_gnt is always zero or one-hot. o_gnt[o_sel_code]=o_en.

Optional Feature:
- MUX_ARB_LOCK_EN defined: adds input port i_lock (1 bit).
  - While in GRANT with i_lock=1 and i_req[o_sel_code]=1, hold expiry is ignored; hold_cnt saturates at HOLD_CYCLES.
  - A request drop still releases, regardless of i_lock.
  - i_lock has no effect in IDLE.
- Not defined: no i_lock port; hold expiry always applies.

Test Plan:
- Reset: assert i_rst mid-grant (o_gnt=8'h10) -> o_gnt=8'h00, o_sel_code=0, o_en=0, o_f=0 before the next clock edge.
- Single requester: i_req=8'h08, i_code=8'h08, HOLD_CYCLES=4 -> after one edge o_gnt=8'h08, o_sel_code=3, o_en=1, o_f=1. Grant holds continuously past 4 cycles via re-grant to 3, with hold_cnt restarting.
- Full contention: i_req=8'hFF from reset -> grants 0,1,2,...,7,0, each lasting exactly 4 cycles, no gap cycles.
- Early drop: i_req=8'h81 -> grant 0. Clear bit 0 after 2 cycles -> next edge o_gnt=8'h80, o_sel_code=7. Clear all -> IDLE, o_en=0, o_sel_code stays 7.
- Wrap-around: after grant 6 releases with i_req=8'h41 -> next grant is 0 (search 7,0), then 6 after hold expiry.
- With MUX_ARB_LOCK_EN: i_req=8'h03, i_lock=1 while 0 granted -> 0 stays granted 10+ cycles. Deassert i_lock -> grant moves to 1 on the next edge.
